l1_threshold_servo: RTL and testbench

- Wishbone master that closes the loop on L1 trigger beam thresholds.
- Each servo iteration:
  - arms the L1 trigger-rate counter;
  - waits for count-done;
  - reads each beam's trigger count;
  - steps that beam's threshold up or down toward a target rate;
  - writes the threshold back over the L1 trigger's Wishbone slave port.
- Sits in the wb_clk domain beside the L1 trigger and shares its slave bus through the upstream interconnect.

---
 rtl/l1_threshold_servo.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_l1_threshold_servo.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l1_threshold_servo.sv
// l1_threshold_servo: Wishbone master that closes the loop on L1 trigger beam
// thresholds. Each iteration arms the trigger-rate counter, waits for the
// count-done edge, reads every beam's count and nudges that beam's threshold
// toward the target rate, writing back only thresholds that changed.
// Optional build macro THRESH_READBACK_EN: every threshold write is followed by
// a readback of the same address; a mismatch sets the sticky err_o.
module l1_threshold_servo #(
   parameter int unsigned NBEAMS      = 2,
   parameter int unsigned THRESH_W    = 18,
   parameter int unsigned INIT_THRESH = 5000,
   parameter int unsigned MIN_THRESH  = 16,
   parameter int unsigned MAX_THRESH  = 262143,
   parameter logic [12:0] CTRL_ADDR   = 13'h1800,
   parameter logic [31:0] CTRL_START  = 32'h2,
   parameter logic [12:0] COUNT_BASE  = 13'h1000,
   parameter logic [12:0] THRESH_BASE = 13'h0800,
   parameter logic [12:0] BEAM_STRIDE = 13'h0200,
   parameter int unsigned WB_TIMEOUT  = 255
) (
   input  logic        wb_clk_i,
   input  logic        wb_rstn_i,
   input  logic        enable_i,
   input  logic [31:0] target_i,
   input  logic [15:0] tol_i,
   input  logic [7:0]  step_i,
   input  logic        trigger_count_done_i,
   output logic        m_wb_cyc_o,
   output logic        m_wb_stb_o,
   output logic        m_wb_we_o,
   output logic [12:0] m_wb_adr_o,
   output logic [31:0] m_wb_dat_o,
   output logic [3:0]  m_wb_sel_o,
   input  logic [31:0] m_wb_dat_i,
   input  logic        m_wb_ack_i,
   output logic        busy_o,
   output logic        iter_done_o,
   output logic [15:0] iter_count_o,
   output logic        err_o
);

   localparam int BW = (NBEAMS > 1) ? $clog2(NBEAMS) : 1;
   localparam int TW = (WB_TIMEOUT > 1) ? $clog2(WB_TIMEOUT) : 1;
   // Wide enough that threshold + step and step + MIN_THRESH never wrap.
   localparam int XW = THRESH_W + 9;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARM,
      S_WAIT_DONE,
      S_RD_CNT,
      S_CALC,
      S_WR_THR,
`ifdef THRESH_READBACK_EN
      S_RB_THR,
`endif
      S_NEXT
   } state_t;

   // Upper edge of the deadband, clamped at the top of the 32-bit range.
   function automatic logic [31:0] band_hi(input logic [31:0] t, input logic [15:0] w);
      logic [32:0] s;
      s = {1'b0, t} + {17'd0, w};
      return s[32] ? 32'hFFFF_FFFF : s[31:0];
   endfunction

   // Lower edge of the deadband, clamped at zero.
   function automatic logic [31:0] band_lo(input logic [31:0] t, input logic [15:0] w);
      return (t >= {16'd0, w}) ? (t - {16'd0, w}) : 32'd0;
   endfunction

   // Raise a threshold by one step, saturating at MAX_THRESH.
   function automatic logic [THRESH_W-1:0] thr_up(input logic [THRESH_W-1:0] thr,
                                                  input logic [7:0] st);
      logic [XW-1:0] s;
      s = XW'(thr) + XW'(st);
      if (s > XW'(MAX_THRESH)) return THRESH_W'(MAX_THRESH);
      return s[THRESH_W-1:0];
   endfunction

   // Lower a threshold by one step, saturating at MIN_THRESH.
   function automatic logic [THRESH_W-1:0] thr_dn(input logic [THRESH_W-1:0] thr,
                                                  input logic [7:0] st);
      if (XW'(thr) < (XW'(st) + XW'(MIN_THRESH))) return THRESH_W'(MIN_THRESH);
      return thr - THRESH_W'(st);
   endfunction

   state_t                state_q, state_d;
   logic                  cyc_q, cyc_d;
   logic                  we_q, we_d;
   logic [12:0]           adr_q, adr_d;
   logic [31:0]           dat_q, dat_d;
   logic [3:0]            sel_q, sel_d;
   logic [TW-1:0]         tmo_q, tmo_d;
   logic [BW-1:0]         b_q, b_d;
   logic [31:0]           cnt_q, cnt_d;
   logic [THRESH_W-1:0]   thr_q [NBEAMS];
   logic [THRESH_W-1:0]   thr_d [NBEAMS];
   logic                  err_q, err_d;
   logic                  idone_q, idone_d;
   logic [15:0]           iter_q, iter_d;
   logic                  dsync1_q, dsync2_q, dsync3_q;

   logic                  done_rise;
   logic                  ack;
   logic                  issue;
   logic [12:0]           b13;
   logic [THRESH_W-1:0]   thr_new;

   // Two-flop synchronizer for the asynchronous count-done level, plus one
   // more flop so its rising edge can be detected.
   always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
      if (!wb_rstn_i) begin
         dsync1_q <= 1'b0;
         dsync2_q <= 1'b0;
         dsync3_q <= 1'b0;
      end else begin
         dsync1_q <= trigger_count_done_i;
         dsync2_q <= dsync1_q;
         dsync3_q <= dsync2_q;
      end
   end

   assign done_rise = dsync2_q & ~dsync3_q;

   // State, bus and servo registers; reset clears the bus immediately and
   // restores every threshold to its power-up value.
   always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
      if (!wb_rstn_i) begin
         state_q <= S_IDLE;
         cyc_q   <= 1'b0;
         we_q    <= 1'b0;
         adr_q   <= '0;
         dat_q   <= '0;
         sel_q   <= '0;
         tmo_q   <= '0;
         b_q     <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         idone_q <= 1'b0;
         iter_q  <= '0;
         for (int i = 0; i < int'(NBEAMS); i++) begin
            thr_q[i] <= THRESH_W'(INIT_THRESH);
         end
      end else begin
         state_q <= state_d;
         cyc_q   <= cyc_d;
         we_q    <= we_d;
         adr_q   <= adr_d;
         dat_q   <= dat_d;
         sel_q   <= sel_d;
         tmo_q   <= tmo_d;
         b_q     <= b_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         idone_q <= idone_d;
         iter_q  <= iter_d;
         for (int i = 0; i < int'(NBEAMS); i++) begin
            thr_q[i] <= thr_d[i];
         end
      end
   end

   // Next-state logic: a bus-issuing state raises cyc on its first cycle (so
   // cyc appears the cycle after entry) and leaves when ack is sampled, which
   // guarantees an idle bus cycle between consecutive transactions.
   always_comb begin
      state_d = state_q;
      cyc_d   = cyc_q;
      we_d    = we_q;
      adr_d   = adr_q;
      dat_d   = dat_q;
      sel_d   = sel_q;
      tmo_d   = tmo_q;
      b_d     = b_q;
      cnt_d   = cnt_q;
      thr_d   = thr_q;
      err_d   = err_q;
      idone_d = 1'b0;
      iter_d  = iter_q;
      thr_new = thr_q[b_q];
      b13     = 13'(b_q);
      ack     = cyc_q & m_wb_ack_i;
      issue   = ~cyc_q;

      // Common handshake and timeout handling for whichever transaction is open.
      if (cyc_q) begin
         if (m_wb_ack_i) begin
            cyc_d = 1'b0;
            tmo_d = '0;
         end else if (tmo_q == TW'(WB_TIMEOUT - 1)) begin
            cyc_d   = 1'b0;
            tmo_d   = '0;
            err_d   = 1'b1;
            state_d = S_IDLE;
         end else begin
            tmo_d = tmo_q + TW'(1);
         end
      end

      case (state_q)
         S_IDLE: begin
            if (enable_i) state_d = S_ARM;
         end
         S_ARM: begin
            if (issue) begin
               cyc_d = 1'b1;
               we_d  = 1'b1;
               sel_d = 4'hF;
               adr_d = CTRL_ADDR;
               dat_d = CTRL_START;
            end else if (ack) begin
               state_d = S_WAIT_DONE;
            end
         end
         S_WAIT_DONE: begin
            if (done_rise) state_d = S_RD_CNT;
         end
         S_RD_CNT: begin
            if (issue) begin
               cyc_d = 1'b1;
               we_d  = 1'b0;
               sel_d = 4'h0;
               adr_d = COUNT_BASE + (b13 << 2);
               dat_d = '0;
            end else if (ack) begin
               cnt_d   = m_wb_dat_i;
               state_d = S_CALC;
            end
         end
         S_CALC: begin
            if (cnt_q > band_hi(target_i, tol_i)) begin
               thr_new = thr_up(thr_q[b_q], step_i);
            end else if (cnt_q < band_lo(target_i, tol_i)) begin
               thr_new = thr_dn(thr_q[b_q], step_i);
            end
            thr_d[b_q] = thr_new;
            state_d    = (thr_new != thr_q[b_q]) ? S_WR_THR : S_NEXT;
         end
         S_WR_THR: begin
            if (issue) begin
               cyc_d = 1'b1;
               we_d  = 1'b1;
               sel_d = 4'hF;
               adr_d = THRESH_BASE + (BEAM_STRIDE * b13);
               dat_d = 32'(thr_q[b_q]);
            end else if (ack) begin
`ifdef THRESH_READBACK_EN
               state_d = S_RB_THR;
`else
               state_d = S_NEXT;
`endif
            end
         end
`ifdef THRESH_READBACK_EN
         S_RB_THR: begin
            if (issue) begin
               cyc_d = 1'b1;
               we_d  = 1'b0;
               sel_d = 4'h0;
               adr_d = THRESH_BASE + (BEAM_STRIDE * b13);
               dat_d = '0;
            end else if (ack) begin
               if (m_wb_dat_i[THRESH_W-1:0] != thr_q[b_q]) err_d = 1'b1;
               state_d = S_NEXT;
            end
         end
`endif
         S_NEXT: begin
            if (b_q == BW'(NBEAMS - 1)) begin
               b_d     = '0;
               idone_d = 1'b1;
               iter_d  = iter_q + 16'd1;
               state_d = S_IDLE;
            end else begin
               b_d     = b_q + BW'(1);
               state_d = S_RD_CNT;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign m_wb_cyc_o   = cyc_q;
   assign m_wb_stb_o   = cyc_q;
   assign m_wb_we_o    = we_q;
   assign m_wb_adr_o   = adr_q;
   assign m_wb_dat_o   = dat_q;
   assign m_wb_sel_o   = sel_q;
   assign busy_o       = (state_q != S_IDLE);
   assign iter_done_o  = idone_q;
   assign iter_count_o = iter_q;
   assign err_o        = err_q;

endmodule

// File: tb/tb_l1_threshold_servo.sv
// Bench for l1_threshold_servo: plays the Wishbone slave (counter, count and
// threshold registers) from one directed/randomized sequence and predicts
// every bus transaction from an arithmetic model of the servo rules.
module tb_l1_threshold_servo;

   localparam int     NB     = 2;
   localparam longint MINT   = 16;
   localparam longint MAXT   = 262143;
   localparam longint INITT  = 5000;
   localparam longint U32MAX = 64'd4294967295;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        enable = 1'b0;
   logic [31:0] target = '0;
   logic [15:0] tol = '0;
   logic [7:0]  step = '0;
   logic        done = 1'b0;
   logic        cyc, stb, we;
   logic [12:0] adr;
   logic [31:0] wdat;
   logic [3:0]  sel;
   logic [31:0] rdat = '0;
   logic        ack = 1'b0;
   logic        busy, idone, err;
   logic [15:0] icnt;

   int     checks = 0;
   int     errors = 0;
   longint mthr [NB];
   longint cnts [NB];
   int     mcnt = 0;
   bit     merr = 1'b0;

   l1_threshold_servo dut (
      .wb_clk_i             (clk),
      .wb_rstn_i            (rstn),
      .enable_i             (enable),
      .target_i             (target),
      .tol_i                (tol),
      .step_i               (step),
      .trigger_count_done_i (done),
      .m_wb_cyc_o           (cyc),
      .m_wb_stb_o           (stb),
      .m_wb_we_o            (we),
      .m_wb_adr_o           (adr),
      .m_wb_dat_o           (wdat),
      .m_wb_sel_o           (sel),
      .m_wb_dat_i           (rdat),
      .m_wb_ack_i           (ack),
      .busy_o               (busy),
      .iter_done_o          (idone),
      .iter_count_o         (icnt),
      .err_o                (err)
   );

   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Servo rule: step up above the band, down below it, clamp at the bounds.
   function automatic longint model_next(longint c, longint t, longint w, longint s, longint th);
      longint hi, lo;
      hi = t + w;
      if (hi > U32MAX) hi = U32MAX;
      lo = t - w;
      if (lo < 0) lo = 0;
      if (c > hi) return (th + s > MAXT) ? MAXT : th + s;
      if (c < lo) return (th - s < MINT) ? MINT : th - s;
      return th;
   endfunction

   // Slave side of one expected transaction: wait for cyc, check the request,
   // hold it for lat cycles, ack, and confirm cyc drops afterwards.
   task automatic serve(input string tag, input bit xwe, input logic [12:0] xadr,
                        input logic [31:0] xdat, input logic [31:0] rd, input int lat);
      int n;
      n = 0;
      while (cyc !== 1'b1 && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk({tag, " cyc"}, 64'(cyc), 64'(1));
      chk({tag, " stb"}, 64'(stb), 64'(1));
      chk({tag, " busy"}, 64'(busy), 64'(1));
      chk({tag, " we"}, 64'(we), 64'(xwe));
      chk({tag, " adr"}, 64'(adr), 64'(xadr));
      chk({tag, " sel"}, 64'(sel), xwe ? 64'hF : 64'h0);
      if (xwe) chk({tag, " dat"}, 64'(wdat), 64'(xdat));
      repeat (lat) @(negedge clk);
      chk({tag, " hold"}, 64'({cyc, we, adr}), 64'({1'b1, xwe, xadr}));
      rdat = rd;
      ack  = 1'b1;
      @(negedge clk);
      ack  = 1'b0;
      rdat = '0;
      chk({tag, " drop"}, 64'(cyc), 64'(0));
   endtask

   task automatic pulse_done();
      done = 1'b1;
      repeat (3) @(negedge clk);
      done = 1'b0;
   endtask

   // One full servo iteration predicted from the model.
   task automatic run_iter(input int lat, input bit early, input bit drop_en, input bit bad_rb);
      longint nt;
      int     n;
      bit     seen;
      if (early) begin
         n = 0;
         while (cyc !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
         end
         done = 1'b1;
         repeat (2) @(negedge clk);
         done = 1'b0;
         serve("ctrl", 1'b1, 13'h1800, 32'h2, 32'h0, 8);
         seen = 1'b0;
         repeat (10) begin
            @(negedge clk);
            if (cyc === 1'b1) seen = 1'b1;
         end
         chk("early_done_ignored", 64'(seen), 64'(0));
      end else begin
         serve("ctrl", 1'b1, 13'h1800, 32'h2, 32'h0, lat);
      end
      if (drop_en) enable = 1'b0;
      pulse_done();
      for (int b = 0; b < NB; b++) begin
         serve("rd_cnt", 1'b0, 13'h1000 + 13'(4 * b), 32'h0, cnts[b][31:0], lat);
         nt = model_next(cnts[b], longint'(target), longint'(tol), longint'(step), mthr[b]);
         if (nt != mthr[b]) begin
            mthr[b] = nt;
            serve("wr_thr", 1'b1, 13'h0800 + 13'(512 * b), 32'(nt), 32'h0, lat);
`ifdef THRESH_READBACK_EN
            serve("rb_thr", 1'b0, 13'h0800 + 13'(512 * b), 32'h0,
                  bad_rb ? (32'(nt) ^ 32'h1) : 32'(nt), lat);
            if (bad_rb) merr = 1'b1;
`endif
         end
      end
      n = 0;
      while (idone !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("iter_done", 64'(idone), 64'(1));
      mcnt = (mcnt + 1) & 16'hFFFF;
      chk("iter_count", 64'(icnt), 64'(mcnt));
      @(negedge clk);
      chk("iter_done_width", 64'(idone), 64'(0));
      chk("err", 64'(err), 64'(merr));
   endtask

   initial begin
      int     n;
      bit     seen;
      bit     last;
      longint hi, lo;
      int     mode;

      // Reset state
      rstn = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_bus", 64'({cyc, stb, we, adr, sel}), 64'(0));
      chk("reset_dat", 64'(wdat), 64'(0));
      chk("reset_status", 64'({busy, idone, icnt, err}), 64'(0));
      rstn = 1'b1;
      @(negedge clk);
      chk("idle_busy", 64'(busy), 64'(0));
      for (int b = 0; b < NB; b++) mthr[b] = INITT;

      // Directed: counts above/below band, with an early done edge during ARM
      target = 32'd1000; tol = 16'd50; step = 8'd10;
      cnts = '{2000, 500};
      enable = 1'b1;
      run_iter(1, 1'b1, 1'b0, 1'b0);

      // Deadband: no threshold writes
      cnts = '{1020, 980};
      run_iter(0, 1'b0, 1'b0, 1'b0);

      // Band edges saturate at the 32-bit limits
      target = 32'hFFFF_FF00; tol = 16'h1000;
      cnts = '{U32MAX, U32MAX};
      run_iter(2, 1'b0, 1'b0, 1'b0);
      target = 32'd10; tol = 16'd100;
      cnts = '{0, 0};
      run_iter(0, 1'b0, 1'b0, 1'b0);

      // Randomized iterations
      repeat (6) begin
         target = 32'($urandom_range(500, 5000));
         tol    = 16'($urandom_range(0, 200));
         step   = 8'($urandom_range(1, 255));
         hi = longint'(target) + longint'(tol);
         lo = longint'(target) - longint'(tol);
         for (int b = 0; b < NB; b++) begin
            mode = int'($urandom_range(0, 2));
            if (mode == 0)      cnts[b] = hi + 1 + longint'($urandom_range(0, 10000));
            else if (mode == 1) cnts[b] = longint'($urandom_range(0, 32'(lo - 1)));
            else                cnts[b] = longint'($urandom_range(32'(lo), 32'(hi)));
         end
         run_iter(int'($urandom_range(0, 3)), 1'b0, 1'b0, 1'b0);
      end

      // enable dropped in WAIT_DONE: iteration completes, then stays idle
      target = 32'd1000; tol = 16'd50; step = 8'd7;
      cnts = '{3000, 10};
      run_iter(1, 1'b0, 1'b1, 1'b0);
      seen = 1'b0;
      repeat (30) begin
         @(negedge clk);
         if (cyc === 1'b1) seen = 1'b1;
      end
      chk("no_ctrl_after_disable", 64'(seen), 64'(0));
      chk("idle_after_disable", 64'(busy), 64'(0));

      // Reset in the middle of a count read
      enable = 1'b1;
      serve("ctrl_pre_reset", 1'b1, 13'h1800, 32'h2, 32'h0, 0);
      pulse_done();
      n = 0;
      while (cyc !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("rd_before_reset", 64'({cyc, we, adr}), 64'({1'b1, 1'b0, 13'h1000}));
      rstn = 1'b0;
      #1;
      chk("reset_async_cyc", 64'(cyc), 64'(0));
      chk("reset_async_busy", 64'(busy), 64'(0));
      @(negedge clk);
      chk("reset_iter_count", 64'(icnt), 64'(0));
      rstn = 1'b1;
      for (int b = 0; b < NB; b++) mthr[b] = INITT;
      mcnt = 0;
      merr = 1'b0;

      // Walk both thresholds down to 20 from the restored 5000, then floor at 16
      target = 32'd1000; tol = 16'd0; step = 8'd249;
      cnts = '{0, 0};
      repeat (20) run_iter(0, 1'b0, 1'b0, 1'b0);
      step = 8'd10;
      run_iter(0, 1'b0, 1'b0, 1'b0);
      run_iter(0, 1'b0, 1'b0, 1'b0);

      // Walk up to MAX_THRESH with maximal counts; one extra iteration holds it
      step = 8'd255;
      cnts = '{U32MAX, U32MAX};
      for (int i = 0; i < 1100; i++) begin
         last = (mthr[0] == MAXT) && (mthr[1] == MAXT);
         run_iter(0, 1'b0, 1'b0, 1'b0);
         if (last) break;
      end

      // Slave never acks the CTRL write
      n = 0;
      while (cyc !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      enable = 1'b0;
      chk("tmo_ctrl_adr", 64'(adr), 64'(13'h1800));
      n = 0;
      seen = 1'b0;
      while (cyc === 1'b1 && n < 400) begin
         if (idone === 1'b1) seen = 1'b1;
         n++;
         @(negedge clk);
      end
      chk("tmo_cycles", 64'(n), 64'(255));
      chk("tmo_err", 64'(err), 64'(1));
      chk("tmo_busy", 64'(busy), 64'(0));
      chk("tmo_no_iter_done", 64'({seen, idone}), 64'(0));
      repeat (10) @(negedge clk);
      chk("tmo_err_sticky", 64'(err), 64'(1));
      rstn = 1'b0;
      @(negedge clk);
      chk("err_cleared_by_reset", 64'(err), 64'(0));
      rstn = 1'b1;
      for (int b = 0; b < NB; b++) mthr[b] = INITT;
      mcnt = 0;
      merr = 1'b0;

`ifdef THRESH_READBACK_EN
      // Readback matching then mismatching
      enable = 1'b1;
      target = 32'd1000; tol = 16'd50; step = 8'd10;
      cnts = '{2000, 500};
      run_iter(1, 1'b0, 1'b0, 1'b0);
      run_iter(0, 1'b0, 1'b0, 1'b1);
      enable = 1'b0;
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
